// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the banked RAM / memory-mapped I/O controller.
// Latency: none (types only).
// Backpressure: not applicable.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_WR,
        RAM_RD,
        IO_WR,
        IO_WAIT_W,
        IO_RD,
        IO_WAIT_R
    } state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;
    localparam logic [31:0] TIMEOUT_DATA    = 32'hDEAD_BEEF;

    // Request fields captured when a transaction is accepted in IDLE.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_io;
    } req_t;

    // A single-bank build still needs a one-bit bank index.
    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/ram_ctrl_decode.sv
// Combinational address decode: word-interleaved bank select, bank row, I/O region hit.
// Latency: 0 cycles.
// Backpressure: none; pure function of the address.
module ram_ctrl_decode
    import ram_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          NUM_BANKS = 2,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter int          BW        = bank_w(NUM_BANKS)
) (
    input  logic [31:0]       addr,
    output logic [BW-1:0]     bank,
    output logic [ADDR_W-1:0] row,
    output logic              is_io
);

    // Address bits above the row field are dropped, so RAM space aliases below IO_BASE.
    generate
        if (NUM_BANKS > 1) begin : g_multi
            localparam int SEL_W = $clog2(NUM_BANKS);
            assign bank = addr[2 +: SEL_W];
            assign row  = addr[2 + SEL_W +: ADDR_W];
        end else begin : g_single
            assign bank = '0;
            assign row  = addr[2 +: ADDR_W];
        end
    endgenerate

    assign is_io = (addr >= IO_BASE);

endmodule

// File: rtl/banked_ram_controller.sv
// RISC-V data-port bridge to banked RAM and memory-mapped I/O; RAM_CTRL_IO_TIMEOUT_EN bounds I/O waits.
// Latency: RAM write 1 cycle, RAM read RD_LAT+1 cycles, I/O 2 cycles plus device busy time.
// Backpressure: riscv_rbusy/riscv_wbusy stall the core; requests are sampled only while idle.
module banked_ram_controller
    import ram_ctrl_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          NUM_BANKS  = 2,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 riscv_addr,
    input  logic [31:0]                 riscv_wdata,
    input  logic [3:0]                  riscv_wmask,
    input  logic                        riscv_rstrb,
    output logic [31:0]                 riscv_rdata,
    output logic                        riscv_rbusy,
    output logic                        riscv_wbusy,
    output logic [NUM_BANKS*ADDR_W-1:0] ram_addr,
    output logic [31:0]                 ram_wdata,
    output logic [NUM_BANKS-1:0]        ram_wen,
    output logic [NUM_BANKS-1:0]        ram_rden,
    output logic [3:0]                  ram_byteena,
    input  logic [NUM_BANKS*32-1:0]     ram_rdata,
    output logic [31:0]                 io_wdata,
    output logic                        io_wen,
    output logic                        io_ren,
    input  logic [31:0]                 io_rdata,
    input  logic                        io_busy,
    output logic                        io_err
);

    localparam int BW  = bank_w(NUM_BANKS);
    localparam int TW  = $clog2(IO_TIMEOUT + 1);
    localparam int RCW = 3;

    state_t                 state_q, state_d;
    req_t                   req_q;
    logic [BW-1:0]          bank_q;
    logic [ADDR_W-1:0]      row_q;
    logic                   pend_rd_q, pend_rd_d;
    logic [RCW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]          io_cnt_q, io_cnt_d, io_cnt_inc;
    logic [31:0]            rdata_q, rdata_nxt, bank_rdata;
    logic                   rdata_ld, take_req, wr_req;
    state_t                 after_wr;
    logic [BW-1:0]          dec_bank;
    logic [ADDR_W-1:0]      dec_row;
    logic                   dec_io;
    logic [NUM_BANKS-1:0]   bank_oh;
`ifdef RAM_CTRL_IO_TIMEOUT_EN
    logic                   err_set;
    logic                   io_err_q;
`endif

    ram_ctrl_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS),
        .IO_BASE   (IO_BASE),
        .BW        (BW)
    ) u_decode (
        .addr  (riscv_addr),
        .bank  (dec_bank),
        .row   (dec_row),
        .is_io (dec_io)
    );

    assign wr_req     = (riscv_wmask != 4'b0000);
    assign bank_rdata = ram_rdata[32*int'(bank_q) +: 32];
    assign io_cnt_inc = (io_cnt_q != TW'(IO_TIMEOUT)) ? io_cnt_q + 1'b1 : io_cnt_q;
    // A combined read+write replays the read against the same decoded target.
    assign after_wr   = pend_rd_q ? (req_q.is_io ? IO_RD : RAM_RD) : IDLE;

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        rd_cnt_d  = '0;
        io_cnt_d  = '0;
        take_req  = 1'b0;
        rdata_ld  = 1'b0;
        rdata_nxt = bank_rdata;
`ifdef RAM_CTRL_IO_TIMEOUT_EN
        err_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wr_req || riscv_rstrb) begin
                    take_req  = 1'b1;
                    pend_rd_d = wr_req && riscv_rstrb;
                    if (wr_req) state_d = dec_io ? IO_WR : RAM_WR;
                    else        state_d = dec_io ? IO_RD : RAM_RD;
                end
            end
            RAM_WR: begin
                state_d   = after_wr;
                pend_rd_d = 1'b0;
            end
            RAM_RD: begin
                // Bank data for the single rden cycle is valid after RD_LAT cycles.
                if (rd_cnt_q == RCW'(RD_LAT)) begin
                    rdata_ld = 1'b1;
                    state_d  = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            IO_WR: state_d = IO_WAIT_W;
            IO_WAIT_W: begin
                io_cnt_d = io_cnt_inc;
                if (!io_busy) begin
                    state_d   = after_wr;
                    pend_rd_d = 1'b0;
                end
`ifdef RAM_CTRL_IO_TIMEOUT_EN
                else if (io_cnt_q == TW'(IO_TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_d   = after_wr;
                    pend_rd_d = 1'b0;
                end
`endif
            end
            IO_RD: state_d = IO_WAIT_R;
            IO_WAIT_R: begin
                io_cnt_d = io_cnt_inc;
                if (!io_busy) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = io_rdata;
                    state_d   = IDLE;
                end
`ifdef RAM_CTRL_IO_TIMEOUT_EN
                else if (io_cnt_q == TW'(IO_TIMEOUT - 1)) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = TIMEOUT_DATA;
                    err_set   = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_rd_q <= 1'b0;
            rd_cnt_q  <= '0;
            io_cnt_q  <= '0;
            req_q     <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            rd_cnt_q  <= rd_cnt_d;
            io_cnt_q  <= io_cnt_d;
            if (take_req) begin
                req_q.wdata <= riscv_wdata;
                req_q.wmask <= riscv_wmask;
                req_q.is_io <= dec_io;
                bank_q      <= dec_bank;
                row_q       <= dec_row;
            end
            if (rdata_ld) rdata_q <= rdata_nxt;
        end
    end

`ifdef RAM_CTRL_IO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)        io_err_q <= 1'b0;
        else if (err_set) io_err_q <= 1'b1;
    end
    assign io_err = io_err_q;
`else
    assign io_err = 1'b0;
`endif

    assign bank_oh     = NUM_BANKS'(1) << bank_q;
    assign ram_addr    = {NUM_BANKS{row_q}};
    assign ram_wdata   = req_q.wdata;
    assign ram_wen     = (state_q == RAM_WR) ? bank_oh : '0;
    assign ram_rden    = (state_q == RAM_RD && rd_cnt_q == '0) ? bank_oh : '0;
    assign ram_byteena = (state_q == RAM_WR) ? req_q.wmask : 4'b0000;
    assign io_wdata    = req_q.wdata;
    assign io_wen      = (state_q == IO_WR);
    assign io_ren      = (state_q == IO_RD);
    assign riscv_rdata = rdata_q;
    assign riscv_rbusy = pend_rd_q || (state_q == RAM_RD) || (state_q == IO_RD) || (state_q == IO_WAIT_R);
    assign riscv_wbusy = (state_q == RAM_WR) || (state_q == IO_WR) || (state_q == IO_WAIT_W);

endmodule

// File: tb/tb_banked_ram_controller.sv
// Scoreboard bench for banked_ram_controller (2 banks, 10-bit rows, RD_LAT=1) with RAM and I/O device models.
module tb_banked_ram_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] riscv_addr, riscv_wdata, riscv_rdata;
    logic [3:0]  riscv_wmask;
    logic        riscv_rstrb, riscv_rbusy, riscv_wbusy;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_wen, ram_rden;
    logic [3:0]  ram_byteena;
    logic [63:0] ram_rdata;
    logic [31:0] io_wdata, io_rdata;
    logic        io_wen, io_ren, io_busy, io_err;

    banked_ram_controller #(
        .ADDR_W(10), .NUM_BANKS(2), .RD_LAT(1), .IO_BASE(32'hFFFF_0000), .IO_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .riscv_addr(riscv_addr), .riscv_wdata(riscv_wdata), .riscv_wmask(riscv_wmask),
        .riscv_rstrb(riscv_rstrb), .riscv_rdata(riscv_rdata),
        .riscv_rbusy(riscv_rbusy), .riscv_wbusy(riscv_wbusy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rden(ram_rden),
        .ram_byteena(ram_byteena), .ram_rdata(ram_rdata),
        .io_wdata(io_wdata), .io_wen(io_wen), .io_ren(io_ren), .io_rdata(io_rdata),
        .io_busy(io_busy), .io_err(io_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM banks, one cycle read latency.
    logic [31:0] mem [2][1024];
    logic [31:0] rd_q [2];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (ram_wen[b])
                for (int k = 0; k < 4; k++)
                    if (ram_byteena[k]) mem[b][ram_addr[b*10 +: 10]][k*8 +: 8] <= ram_wdata[k*8 +: 8];
            if (ram_rden[b]) rd_q[b] <= mem[b][ram_addr[b*10 +: 10]];
        end
    end
    assign ram_rdata = {rd_q[1], rd_q[0]};

    // I/O device: busy for io_hold cycles after each access pulse.
    int io_hold = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (io_wen || io_ren)  busy_cnt <= io_hold;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign io_busy = (busy_cnt != 0);

    typedef struct packed {logic bank; logic [9:0] row; logic [3:0] be; logic [31:0] dat;} ram_exp_t;
    typedef struct packed {logic is_wr; logic [31:0] dat;} io_exp_t;
    typedef struct packed {logic [31:0] dat; logic [15:0] len;} rd_exp_t;

    ram_exp_t    q_wr[$];
    ram_exp_t    q_rd[$];
    io_exp_t     q_io[$];
    rd_exp_t     q_rresp[$];
    logic [15:0] q_wresp[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic b, input logic [9:0] r, input logic [3:0] be, input logic [31:0] d);
        q_wr.push_back('{bank: b, row: r, be: be, dat: d});
    endtask
    task automatic exp_rd(input logic b, input logic [9:0] r);
        q_rd.push_back('{bank: b, row: r, be: 4'h0, dat: 32'h0});
    endtask
    task automatic exp_io(input logic w, input logic [31:0] d);
        q_io.push_back('{is_wr: w, dat: d});
    endtask
    task automatic exp_rresp(input logic [31:0] d, input logic [15:0] len);
        q_rresp.push_back('{dat: d, len: len});
    endtask
    task automatic exp_wresp(input logic [15:0] len);
        q_wresp.push_back(len);
    endtask

    // Monitor: every strobe and every busy fall is matched against the scoreboard.
    ram_exp_t    m_wr, m_rd;
    io_exp_t     m_io;
    rd_exp_t     m_rr;
    logic [15:0] m_wl;
    int unsigned rlen = 0, wlen = 0;
    always @(negedge clk) begin
        if (ram_wen != 2'b00) begin
            if (q_wr.size() == 0) check("unexpected ram_wen", {30'b0, ram_wen}, 32'h0);
            else begin
                m_wr = q_wr.pop_front();
                check("ram_wen", {30'b0, ram_wen}, 32'd1 << m_wr.bank);
                check("wr row", ram_addr[int'(m_wr.bank)*10 +: 10], m_wr.row);
                check("byteena", ram_byteena, m_wr.be);
                check("ram_wdata", ram_wdata, m_wr.dat);
            end
        end
        if (ram_rden != 2'b00) begin
            if (q_rd.size() == 0) check("unexpected ram_rden", {30'b0, ram_rden}, 32'h0);
            else begin
                m_rd = q_rd.pop_front();
                check("ram_rden", {30'b0, ram_rden}, 32'd1 << m_rd.bank);
                check("rd row", ram_addr[int'(m_rd.bank)*10 +: 10], m_rd.row);
            end
        end
        if (io_wen || io_ren) begin
            if (q_io.size() == 0) check("unexpected io strobe", {30'b0, io_wen, io_ren}, 32'h0);
            else begin
                m_io = q_io.pop_front();
                check("io strobe kind", {30'b0, io_wen, io_ren}, m_io.is_wr ? 32'd2 : 32'd1);
                if (io_wen) check("io_wdata", io_wdata, m_io.dat);
            end
        end
        if (reset) begin
            rlen = 0;
            wlen = 0;
        end else begin
            if (riscv_rbusy) rlen++;
            else if (rlen != 0) begin
                if (q_rresp.size() == 0) check("unexpected read completion", rlen, 32'h0);
                else begin
                    m_rr = q_rresp.pop_front();
                    check("rbusy cycles", rlen, m_rr.len);
                    check("riscv_rdata", riscv_rdata, m_rr.dat);
                end
                rlen = 0;
            end
            if (riscv_wbusy) wlen++;
            else if (wlen != 0) begin
                if (q_wresp.size() == 0) check("unexpected write completion", wlen, 32'h0);
                else begin
                    m_wl = q_wresp.pop_front();
                    check("wbusy cycles", wlen, m_wl);
                end
                wlen = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic rd);
        @(negedge clk);
        riscv_addr  = a;
        riscv_wdata = wd;
        riscv_wmask = wm;
        riscv_rstrb = rd;
        @(posedge clk);
        #1;
        riscv_wmask = 4'h0;
        riscv_rstrb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((riscv_rbusy || riscv_wbusy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle within 200 cycles", {30'b0, riscv_rbusy, riscv_wbusy}, 32'h0);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic rd);
        issue(a, wd, wm, rd);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; riscv_addr = '0; riscv_wdata = '0; riscv_wmask = '0; riscv_rstrb = 1'b0;
        io_rdata = 32'h5A5A_C3C3;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset rbusy", riscv_rbusy, 32'h0);
        check("reset wbusy", riscv_wbusy, 32'h0);
        check("reset ram_wen", {30'b0, ram_wen}, 32'h0);
        check("reset ram_rden", {30'b0, ram_rden}, 32'h0);
        check("reset ram_addr", {12'b0, ram_addr}, 32'h0);
        check("reset byteena", ram_byteena, 32'h0);
        check("reset riscv_rdata", riscv_rdata, 32'h0);
        check("reset io strobes", {30'b0, io_wen, io_ren}, 32'h0);
        check("reset io_err", io_err, 32'h0);

        exp_wr(1, 10'h0, 4'hF, 32'h8765_4321); exp_wresp(1);
        op(32'h4, 32'h8765_4321, 4'hF, 1'b0);
        exp_rd(1, 10'h0); exp_rresp(32'h8765_4321, 2);
        op(32'h4, 32'h0, 4'h0, 1'b1);
        exp_wr(1, 10'h0, 4'hF, 32'hABCD_1234); exp_wresp(1);
        op(32'h4, 32'hABCD_1234, 4'hF, 1'b0);
        exp_rd(1, 10'h0); exp_rresp(32'hABCD_1234, 2);
        op(32'h4, 32'h0, 4'h0, 1'b1);

        // Combined read+write: write lands first, read sees the merged word.
        exp_wr(0, 10'h1, 4'hF, 32'h1122_3344); exp_wresp(1);
        op(32'h8, 32'h1122_3344, 4'hF, 1'b0);
        exp_wr(0, 10'h1, 4'b1000, 32'hAA00_0000); exp_wresp(1);
        exp_rd(0, 10'h1); exp_rresp(32'hAA22_3344, 3);
        op(32'h8, 32'hAA00_0000, 4'b1000, 1'b1);

        exp_wr(1, 10'h1, 4'hF, 32'hFFFF_FFFF); exp_wresp(1);
        op(32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        exp_wr(1, 10'h1, 4'b0101, 32'h1234_5678); exp_wresp(1);
        op(32'hC, 32'h1234_5678, 4'b0101, 1'b0);
        exp_rd(1, 10'h1); exp_rresp(32'hFF34_FF78, 2);
        op(32'hC, 32'h0, 4'h0, 1'b1);

        // Upper address bits wrap onto the same row.
        exp_rd(1, 10'h0); exp_rresp(32'hABCD_1234, 2);
        op(32'h2004, 32'h0, 4'h0, 1'b1);
        exp_wr(1, 10'h3FF, 4'hF, 32'h0BAD_F00D); exp_wresp(1);
        op(32'hFFFE_FFFC, 32'h0BAD_F00D, 4'hF, 1'b0);
        exp_rd(1, 10'h3FF); exp_rresp(32'h0BAD_F00D, 2);
        op(32'h1FFC, 32'h0, 4'h0, 1'b1);

        // A write presented while a read is busy must be ignored.
        exp_rd(0, 10'h1); exp_rresp(32'hAA22_3344, 2);
        @(negedge clk);
        riscv_addr = 32'h8; riscv_rstrb = 1'b1; riscv_wmask = 4'h0;
        @(posedge clk); #1;
        riscv_rstrb = 1'b0; riscv_wmask = 4'hF; riscv_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        riscv_wmask = 4'h0;
        wait_idle();
        exp_rd(0, 10'h1); exp_rresp(32'hAA22_3344, 2);
        op(32'h8, 32'h0, 4'h0, 1'b1);

        io_hold = 3;
        exp_io(1, 32'hCAFE_F00D); exp_wresp(5);
        op(32'hFFFF_FFFF, 32'hCAFE_F00D, 4'hF, 1'b0);
        exp_io(0, 32'h0); exp_rresp(32'h5A5A_C3C3, 5);
        op(32'hFFFF_0000, 32'h0, 4'h0, 1'b1);
        exp_wr(0, 10'h2, 4'hF, 32'h0102_0304); exp_wresp(1);
        op(32'h10, 32'h0102_0304, 4'hF, 1'b0);
        check("rdata held across write", riscv_rdata, 32'h5A5A_C3C3);

`ifdef RAM_CTRL_IO_TIMEOUT_EN
        io_hold = 100;
        exp_io(0, 32'h0); exp_rresp(32'hDEAD_BEEF, 17);
        op(32'hFFFF_0004, 32'h0, 4'h0, 1'b1);
        check("io_err after timeout", io_err, 32'h1);
`else
        io_hold = 40;
        io_rdata = 32'h1357_9BDF;
        exp_io(0, 32'h0); exp_rresp(32'h1357_9BDF, 42);
        op(32'hFFFF_0004, 32'h0, 4'h0, 1'b1);
        check("io_err without timeout", io_err, 32'h0);
`endif

        // Reset during the rden cycle of a RAM read.
        exp_rd(1, 10'h0);
        issue(32'h4, 32'h0, 4'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset mid-read rbusy", riscv_rbusy, 32'h0);
        check("reset mid-read rden", {30'b0, ram_rden}, 32'h0);
        check("reset mid-read rdata", riscv_rdata, 32'h0);
        check("reset clears io_err", io_err, 32'h0);
        reset = 1'b0;
        exp_rd(1, 10'h0); exp_rresp(32'hABCD_1234, 2);
        op(32'h4, 32'h0, 4'h0, 1'b1);

        repeat (3) @(negedge clk);
        check("pending ram writes", q_wr.size(), 32'h0);
        check("pending ram reads", q_rd.size(), 32'h0);
        check("pending io strobes", q_io.size(), 32'h0);
        check("pending read completions", q_rresp.size(), 32'h0);
        check("pending write completions", q_wresp.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
